if_prefetch_unit: RTL and testbench

//  Next-gen instruction fetch stage: PC generator + word-wide instruction memory + prefetch queue.

---
 rtl/if_pkg.sv | 27 ++
 rtl/if_fetch_fifo.sv | 82 ++++++++
 rtl/if_prefetch_unit.sv | 153 +++++++++++++++
 tb/tb_if_prefetch_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch prefetch unit:
//   HALT_OPCODE    opcode field value that stops fetching (when halt
//                  detection is compiled in via IF_HALT_DETECT_EN)
//   redirect_e     which redirect source is steering fetch this cycle
//   fetch_entry_t  one prefetch queue entry {instruction, pc+4} for the
//                  default 32-bit datapath
// -----------------------------------------------------------------------------
package if_pkg;

    localparam logic [5:0] HALT_OPCODE = 6'h3F;
    localparam int         IF_NB_REG   = 32;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_BR   = 2'd1,
        RD_J    = 2'd2,
        RD_JR   = 2'd3
    } redirect_e;

    typedef struct packed {
        logic [IF_NB_REG-1:0] instr;
        logic [IF_NB_REG-1:0] pcplus4;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// -----------------------------------------------------------------------------
// if_fetch_fifo
// Synchronous FIFO holding prefetched {instruction, pc+4} entries.
// The head is read straight out of the storage registers, so there is no
// combinational path from the write data to o_data.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset (pointers/count only)
//   i_en             global enable; 0 freezes all state
//   i_flush          empty the queue; beats a simultaneous push/pop
//   i_push, i_data   write one entry (accepted when not full, or full + pop)
//   i_pop            drop the head entry (ignored when empty)
//   o_data           head entry
//   o_count          number of held entries (0..DEPTH)
//   o_full, o_empty  status flags
// -----------------------------------------------------------------------------
module if_fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_en,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // When full, a push is legal only alongside a pop: the slot being
    // written is the head that leaves on the same edge.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_en) begin
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Entry storage carries no reset; only the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (i_en && !i_flush && w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// -----------------------------------------------------------------------------
// if_prefetch_unit
// Instruction fetch stage: fetch PC generator, word-organised instruction
// memory (async read, debug write port) and a DEPTH-entry prefetch queue
// delivering {instruction, pc+4} to decode over a valid/ready handshake.
// Optional feature macro: IF_HALT_DETECT_EN -- stop fetching after queuing
// a word whose opcode is HALT_OPCODE; o_halted stays 1 until reset.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_dunit_clk_en        step enable; 0 freezes everything but memory writes
//   i_dunit_w_en/addr/data debug memory write port
//   i_branch/_target      taken-branch redirect
//   i_jump/_index         J/JAL redirect, upper bits from i_redirect_pcplus4
//   i_jreg/_target        JR/JALR redirect
//   i_ready               decode accepts the head entry
//   o_valid, o_instruction, o_pcplus4  head entry (data zeroed when invalid)
//   o_halted              fetch stopped on HALT
// -----------------------------------------------------------------------------
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int          NB_REG   = 32,
    parameter int          NB_ADDR  = 9,
    parameter int          NB_INST  = 26,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_dunit_clk_en,
    input  logic               i_dunit_w_en,
    input  logic [NB_ADDR-1:0] i_dunit_addr,
    input  logic [NB_REG-1:0]  i_dunit_data,
    input  logic               i_branch,
    input  logic [NB_REG-1:0]  i_branch_target,
    input  logic               i_jump,
    input  logic [NB_INST-1:0] i_jump_index,
    input  logic [NB_REG-1:0]  i_redirect_pcplus4,
    input  logic               i_jreg,
    input  logic [NB_REG-1:0]  i_jreg_target,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [NB_REG-1:0]  o_instruction,
    output logic [NB_REG-1:0]  o_pcplus4,
    output logic               o_halted
);

    localparam int MEM_WORDS = 2 ** (NB_ADDR - 2);
    localparam int CW        = $clog2(DEPTH) + 1;

    logic [NB_REG-1:0]   r_mem [MEM_WORDS];
    logic [NB_REG-1:0]   r_fpc;
    logic [NB_REG-1:0]   w_fetch_word;
    logic [NB_REG-1:0]   w_target;
    redirect_e           w_sel;
    logic                w_redirect;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_halted;
    logic [2*NB_REG-1:0] w_head;
    logic [CW-1:0]       w_count;
    logic                w_unused_bits;

    // Debug writes land regardless of the step enable.
    always_ff @(posedge i_clk) begin
        if (i_dunit_w_en) begin
            r_mem[i_dunit_addr[NB_ADDR-1:2]] <= i_dunit_data;
        end
    end

    // Index wraps modulo the memory size; upper PC bits are ignored.
    assign w_fetch_word = r_mem[r_fpc[NB_ADDR-1:2]];

    always_comb begin
        w_sel    = RD_NONE;
        w_target = '0;
        if (i_jreg) begin
            w_sel    = RD_JR;
            w_target = i_jreg_target;
        end else if (i_jump) begin
            w_sel    = RD_J;
            w_target = {i_redirect_pcplus4[NB_REG-1:NB_INST+2], i_jump_index, 2'b00};
        end else if (i_branch) begin
            w_sel    = RD_BR;
            w_target = i_branch_target;
        end
    end

    assign w_redirect = (w_sel != RD_NONE);

    // A redirect flushes the queue, so neither a pop nor a push may happen
    // in that cycle.
    assign w_pop  = o_valid & i_ready & ~w_redirect;
    assign w_push = ~w_redirect & ~w_halted & ~i_dunit_w_en & (~w_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fpc <= NB_REG'(RESET_PC);
        end else if (i_dunit_clk_en) begin
            if (w_redirect) begin
                r_fpc <= w_target;
            end else if (w_push) begin
                r_fpc <= r_fpc + NB_REG'(4);
            end
        end
    end

`ifdef IF_HALT_DETECT_EN
    logic r_halted;

    // The HALT word itself is queued; only the pushes after it stop.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_halted <= 1'b0;
        end else if (i_dunit_clk_en && w_push &&
                     (w_fetch_word[NB_REG-1:NB_REG-6] == HALT_OPCODE)) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

    if_fetch_fifo #(
        .W     (2 * NB_REG),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (i_dunit_clk_en),
        .i_flush (w_redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({w_fetch_word, r_fpc + NB_REG'(4)}),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_valid       = ~w_empty;
    assign o_instruction = o_valid ? w_head[2*NB_REG-1:NB_REG] : '0;
    assign o_pcplus4     = o_valid ? w_head[NB_REG-1:0]        : '0;
    assign o_halted      = w_halted;

    assign w_unused_bits = &{1'b0, i_dunit_addr[1:0], r_fpc[NB_REG-1:NB_ADDR],
                             r_fpc[1:0], i_redirect_pcplus4[NB_INST+1:0], w_count};

endmodule

// File: tb/tb_if_prefetch_unit.sv
module tb_if_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b1;
    logic        w_en = 1'b0;
    logic [8:0]  daddr = '0;
    logic [31:0] ddata = '0;
    logic        br = 1'b0;
    logic [31:0] brt = '0;
    logic        jmp = 1'b0;
    logic [25:0] jidx = '0;
    logic [31:0] rpc4 = '0;
    logic        jr = 1'b0;
    logic [31:0] jrt = '0;
    logic        ready = 1'b0;
    logic        o_valid;
    logic [31:0] o_instruction;
    logic [31:0] o_pcplus4;
    logic        o_halted;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem_model [128];
    logic [63:0] sb [$];
    logic [63:0] exp_e;

    always #5 clk = ~clk;

    if_prefetch_unit dut (
        .i_clk              (clk),
        .i_reset            (rst),
        .i_dunit_clk_en     (clk_en),
        .i_dunit_w_en       (w_en),
        .i_dunit_addr       (daddr),
        .i_dunit_data       (ddata),
        .i_branch           (br),
        .i_branch_target    (brt),
        .i_jump             (jmp),
        .i_jump_index       (jidx),
        .i_redirect_pcplus4 (rpc4),
        .i_jreg             (jr),
        .i_jreg_target      (jrt),
        .i_ready            (ready),
        .o_valid            (o_valid),
        .o_instruction      (o_instruction),
        .o_pcplus4          (o_pcplus4),
        .o_halted           (o_halted)
    );

    function automatic logic [63:0] exp_at(input logic [31:0] pc);
        logic [6:0] idx;
        idx = pc[8:2];
        return {mem_model[idx], pc + 32'd4};
    endfunction

    // Expected stream: n consecutive words starting at pc.
    task automatic sb_fill(input logic [31:0] pc, input int n);
        sb.delete();
        for (int k = 0; k < n; k++) sb.push_back(exp_at(pc + 32'(4 * k)));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [8:0] addr, input logic [31:0] data);
        daddr = addr;
        ddata = data;
        w_en  = 1'b1;
        step();
        w_en  = 1'b0;
        mem_model[addr[8:2]] = data;
    endtask

    task automatic do_reset;
        ready = 1'b0;
        rst   = 1'b1;
        step();
        step();
        rst   = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 128; i++) write_word(9'(i * 4), 32'h0100_0000 + 32'h0001_0003 * 32'(i));
        do_reset();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        total++; if (o_instruction !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", o_instruction); end
        total++; if (o_pcplus4 !== 32'h0) begin bad++; $display("FAIL reset_pcplus4: got %h want 0", o_pcplus4); end
        total++; if (o_halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", o_halted); end
        total++; if (dut.r_fpc !== 32'h0) begin bad++; $display("FAIL reset_fpc: got %h want 0", dut.r_fpc); end
    endtask

    task automatic test_stream;
        int cyc;
        int gaps;
        do_reset();
        ready = 1'b1;
        sb_fill(32'h0, 8);
        step();
        total++; if (o_valid !== 1'b1 || o_pcplus4 !== 32'd4) begin
            bad++; $display("FAIL first_latency: got valid=%b pc4=%h want 1/4", o_valid, o_pcplus4);
        end
        cyc = 0; gaps = 0;
        while (sb.size() > 0 && cyc < 60) begin
            if (o_valid && ready) begin
                exp_e = sb.pop_front();
                total++;
                if ({o_instruction, o_pcplus4} !== exp_e) begin
                    bad++; $display("FAIL stream_entry: got %h/%h want %h/%h", o_instruction, o_pcplus4, exp_e[63:32], exp_e[31:0]);
                end
            end else gaps++;
            step(); cyc++;
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL stream_timeout: got %0d left want 0", sb.size()); end
        total++; if (gaps != 0) begin bad++; $display("FAIL stream_gapless: got %0d gaps want 0", gaps); end
    endtask

    task automatic test_backpressure;
        int cyc;
        do_reset();
        repeat (10) step();
        total++; if (dut.r_fpc !== 32'd16) begin bad++; $display("FAIL bp_fpc: got %h want 10", dut.r_fpc); end
        total++; if (o_valid !== 1'b1 || o_pcplus4 !== 32'd4) begin
            bad++; $display("FAIL bp_head: got valid=%b pc4=%h want 1/4", o_valid, o_pcplus4);
        end
        ready = 1'b1;
        sb_fill(32'h0, 16);
        cyc = 0;
        while (sb.size() > 0 && cyc < 80) begin
            if (o_valid && ready) begin
                exp_e = sb.pop_front();
                total++;
                if ({o_instruction, o_pcplus4} !== exp_e) begin
                    bad++; $display("FAIL bp_entry: got %h/%h want %h/%h", o_instruction, o_pcplus4, exp_e[63:32], exp_e[31:0]);
                end
            end
            step(); cyc++;
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_timeout: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_jump;
        int cyc;
        do_reset();
        repeat (6) step();
        jmp = 1'b1; jidx = 26'h10; rpc4 = 32'h1000_0008;
        step();
        jmp = 1'b0; ready = 1'b1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL jump_flush: got valid=%b want 0", o_valid); end
        total++; if (dut.r_fpc !== 32'h1000_0040) begin bad++; $display("FAIL jump_target: got %h want 10000040", dut.r_fpc); end
        step();
        total++; if (o_valid !== 1'b1 || o_pcplus4 !== 32'h1000_0044) begin
            bad++; $display("FAIL jump_first: got valid=%b pc4=%h want 1/10000044", o_valid, o_pcplus4);
        end
        sb_fill(32'h1000_0040, 6);
        cyc = 0;
        while (sb.size() > 0 && cyc < 40) begin
            if (o_valid && ready) begin
                exp_e = sb.pop_front();
                total++;
                if ({o_instruction, o_pcplus4} !== exp_e) begin
                    bad++; $display("FAIL jump_entry: got %h/%h want %h/%h", o_instruction, o_pcplus4, exp_e[63:32], exp_e[31:0]);
                end
            end
            step(); cyc++;
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL jump_timeout: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_redirect_priority;
        int cyc;
        do_reset();
        ready = 1'b1;
        repeat (4) step();
        jr = 1'b1; jrt = 32'h40; br = 1'b1; brt = 32'h80;
        step();
        jr = 1'b0; br = 1'b0;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL prio_flush: got valid=%b want 0", o_valid); end
        sb_fill(32'h40, 5);
        cyc = 0;
        while (sb.size() > 0 && cyc < 40) begin
            if (o_valid && ready) begin
                exp_e = sb.pop_front();
                total++;
                if ({o_instruction, o_pcplus4} !== exp_e) begin
                    bad++; $display("FAIL prio_entry: got %h/%h want %h/%h", o_instruction, o_pcplus4, exp_e[63:32], exp_e[31:0]);
                end
            end
            step(); cyc++;
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL prio_timeout: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_clk_en;
        int          cyc;
        int          taken;
        logic [31:0] held_pc4;
        logic [31:0] held_fpc;
        do_reset();
        ready = 1'b1;
        sb_fill(32'h0, 12);
        cyc = 0; taken = 0;
        while (taken < 3 && cyc < 20) begin
            if (o_valid && ready) begin
                exp_e = sb.pop_front(); taken++;
                total++;
                if ({o_instruction, o_pcplus4} !== exp_e) begin
                    bad++; $display("FAIL en_pre_entry: got %h/%h want %h/%h", o_instruction, o_pcplus4, exp_e[63:32], exp_e[31:0]);
                end
            end
            step(); cyc++;
        end
        held_pc4 = o_pcplus4;
        held_fpc = dut.r_fpc;
        clk_en = 1'b0;
        repeat (5) begin
            step();
            total++; if (o_valid !== 1'b1 || o_pcplus4 !== held_pc4) begin
                bad++; $display("FAIL en_frozen_head: got valid=%b pc4=%h want 1/%h", o_valid, o_pcplus4, held_pc4);
            end
        end
        total++; if (dut.r_fpc !== held_fpc) begin bad++; $display("FAIL en_frozen_fpc: got %h want %h", dut.r_fpc, held_fpc); end
        clk_en = 1'b1;
        cyc = 0;
        while (sb.size() > 0 && cyc < 40) begin
            if (o_valid && ready) begin
                exp_e = sb.pop_front();
                total++;
                if ({o_instruction, o_pcplus4} !== exp_e) begin
                    bad++; $display("FAIL en_post_entry: got %h/%h want %h/%h", o_instruction, o_pcplus4, exp_e[63:32], exp_e[31:0]);
                end
            end
            step(); cyc++;
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL en_timeout: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_halt;
        int          cyc;
        logic [31:0] saved;
        saved = mem_model[3];
        write_word(9'h0C, 32'hFC00_0000);
        do_reset();
        ready = 1'b1;
`ifdef IF_HALT_DETECT_EN
        sb_fill(32'h0, 4);
`else
        sb_fill(32'h0, 8);
`endif
        cyc = 0;
        while (sb.size() > 0 && cyc < 40) begin
            if (o_valid && ready) begin
                exp_e = sb.pop_front();
                total++;
                if ({o_instruction, o_pcplus4} !== exp_e) begin
                    bad++; $display("FAIL halt_entry: got %h/%h want %h/%h", o_instruction, o_pcplus4, exp_e[63:32], exp_e[31:0]);
                end
            end
            step(); cyc++;
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL halt_timeout: got %0d left want 0", sb.size()); end
`ifdef IF_HALT_DETECT_EN
        repeat (3) step();
        total++; if (o_valid !== 1'b0 || o_halted !== 1'b1) begin
            bad++; $display("FAIL halt_stop: got valid=%b halted=%b want 0/1", o_valid, o_halted);
        end
        do_reset();
        total++; if (o_halted !== 1'b0) begin bad++; $display("FAIL halt_reset: got %b want 0", o_halted); end
`else
        total++; if (o_halted !== 1'b0 || o_valid !== 1'b1) begin
            bad++; $display("FAIL halt_ignored: got halted=%b valid=%b want 0/1", o_halted, o_valid);
        end
`endif
        write_word(9'h0C, saved);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_jump();
        test_redirect_priority();
        test_clk_en();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
